modo_scheduler: RTL

Two-requester scheduler for the shared 4-bit mode counter. Accepts counting jobs (mode, start value, step count) from two clients. Arbitrates between them round-robin, then drives the counter's enable/modo/d through a load-then-run sequence. Returns the final count and a wrap flag to the granted client. Sits directly in front of the mode counter; the clients never touch the counter ports.

---
 rtl/modo_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/modo_scheduler.sv
// modo_scheduler
// Two-requester front end for the shared 4-bit mode counter. Each client
// submits a counting job (mode, start value, step count). Jobs are granted
// round-robin and executed as LOAD -> RUN x len -> DONE on the counter
// interface. The final count and a wrap flag go back to the granted client.
//
// Ports
//   i_clk, i_rst            clock (rising edge), async active-low reset
//   i_req0/1                level job request per client
//   i_mode0/1               job mode: 00 up1, 01 down1, 10 down3, 11 load
//   i_load0/1 [CNT_W]       start value
//   i_len0/1  [LEN_W]       counting cycles after the load
//   o_gnt0/1                client owns the counter (grant .. DONE cycle)
//   o_done0/1               one-cycle pulse, o_result/o_wrap valid
//   o_result  [CNT_W]       counter value at job end, held until next done
//   o_wrap                  counter rco seen during the job
//   o_cnt_enable/modo/d     drive the counter
//   i_cnt_q, i_cnt_rco      counter state feedback
module modo_scheduler #(
  parameter int CNT_W = 4,
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [1:0]       i_mode0,
  input  logic [1:0]       i_mode1,
  input  logic [CNT_W-1:0] i_load0,
  input  logic [CNT_W-1:0] i_load1,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [CNT_W-1:0] o_result,
  output logic             o_wrap,
  output logic             o_cnt_enable,
  output logic [1:0]       o_cnt_modo,
  output logic [CNT_W-1:0] o_cnt_d,
  input  logic [CNT_W-1:0] i_cnt_q,
  input  logic             i_cnt_rco
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODO_LOAD = 2'b11;

  state_t           r_state;
  state_t           w_next;

  logic             r_last;     // last client served
  logic             r_owner;    // client owning the current job
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_load;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_rem;      // RUN cycles still to go
  logic             r_acc;      // rco accumulator over RUN cycles
  logic [1:0]       r_done;
  logic [CNT_W-1:0] r_result;
  logic             r_wrap;

  logic             w_any_req;
  logic             w_win;

  // Round-robin: on contention the client that was not served last wins.
  assign w_any_req = i_req0 | i_req1;
  assign w_win     = (i_req0 & i_req1) ? ~r_last : i_req1;

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_LOAD;
      S_LOAD:  w_next = (r_len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (r_rem == LEN_W'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job latch, step counter, rco accumulation and result capture.
  // Job fields are sampled only at grant; later input changes are ignored.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_mode   <= '0;
      r_load   <= '0;
      r_len    <= '0;
      r_rem    <= '0;
      r_acc    <= 1'b0;
      r_done   <= '0;
      r_result <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_win;
            r_mode  <= w_win ? i_mode1 : i_mode0;
            r_load  <= w_win ? i_load1 : i_load0;
            r_len   <= w_win ? i_len1  : i_len0;
          end
        end
        S_LOAD: begin
          r_rem <= r_len;
          r_acc <= 1'b0;
        end
        S_RUN: begin
          r_rem <= r_rem - LEN_W'(1);
          r_acc <= r_acc | i_cnt_rco;
        end
        S_DONE: begin
          // rco from the final RUN step only becomes visible here.
          r_result        <= i_cnt_q;
          r_wrap          <= r_acc | i_cnt_rco;
          r_done[r_owner] <= 1'b1;
          r_last          <= r_owner;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  assign o_gnt0   = (r_state != S_IDLE) & ~r_owner;
  assign o_gnt1   = (r_state != S_IDLE) &  r_owner;
  assign o_done0  = r_done[0];
  assign o_done1  = r_done[1];
  assign o_result = r_result;
  assign o_wrap   = r_wrap;

  always_comb begin
    o_cnt_enable = 1'b0;
    o_cnt_modo   = 2'b00;
    o_cnt_d      = '0;
    case (r_state)
      S_LOAD: begin
        o_cnt_enable = 1'b1;
        o_cnt_modo   = MODO_LOAD;
        o_cnt_d      = r_load;
      end
      S_RUN: begin
        o_cnt_enable = 1'b1;
        o_cnt_modo   = r_mode;
        o_cnt_d      = r_load;
      end
      default: ;
    endcase
  end

endmodule
